// File: rtl/pll_reset_seq_if.sv
// Purpose : bundles the PLL handshake and reset outputs of the reset sequencer.
// Latency : none, wiring only.
// Backpressure: none; level signals only.
// master: sequencer side (samples pll_locked/btn_rst_n, drives pll_rst, resets, status).
// slave : board/PLL side (drives pll_locked/btn_rst_n, observes the rest).
interface pll_reset_seq_if;
    logic       pll_locked;    // PLL lock indication, asynchronous to clk
    logic       btn_rst_n;     // reset pushbutton, active-low, asynchronous
    logic       pll_rst;       // PLL reset, active-high
    logic       sys_rst_n;     // system reset, active-low
    logic       cpu_rst_n;     // CPU reset, active-low
    logic [3:0] lock_retries;  // saturating count of lock timeouts
    logic       lock_lost;     // sticky: lock dropped after release

    modport master (
        input  pll_locked,
        input  btn_rst_n,
        output pll_rst,
        output sys_rst_n,
        output cpu_rst_n,
        output lock_retries,
        output lock_lost
    );

    modport slave (
        output pll_locked,
        output btn_rst_n,
        input  pll_rst,
        input  sys_rst_n,
        input  cpu_rst_n,
        input  lock_retries,
        input  lock_lost
    );
endinterface

// File: rtl/pll_reset_seq.sv
// Purpose : PLL reset sequencer; pulses pll_rst, waits for stable lock, then releases sys then cpu reset.
// Latency : sys_rst_n rises SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges after lock rises; cpu_rst_n STAGGER_CYCLES later.
// Backpressure: none; level outputs, re-asserted on lock loss or button.
// Ports: clk (board reference clock, also PLL refclk), rst_n (async active-low),
//        bus (pll_reset_seq_if.master: pll_locked, btn_rst_n in; pll_rst, sys_rst_n,
//        cpu_rst_n, lock_retries, lock_lost out). All outputs are registered.
// Optional: define PLL_RESET_SEQ_DEBOUNCE_EN to debounce the button over DEBOUNCE_CYCLES.
module pll_reset_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES     = 250000
) (
    input  logic            clk,
    input  logic            rst_n,
    pll_reset_seq_if.master bus
);

    // Synchronizer depth never drops below two flops.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_SYS_REL   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    logic [SYNC_N-1:0] lock_sync;
    logic [SYNC_N-1:0] btn_sync;
    logic              locked_s;
    logic              btn_s;
    logic              btn_use;

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        retries, retries_nxt;
    logic              lost, lost_nxt;
    logic              pll_rst_q, sys_rst_q, cpu_rst_q;

    // The button synchronizer resets to the released level so that leaving
    // rst_n is not mistaken for a press; the lock synchronizer resets to "unlocked".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
            btn_sync  <= '1;
        end else begin
            lock_sync <= {lock_sync[SYNC_N-2:0], bus.pll_locked};
            btn_sync  <= {btn_sync[SYNC_N-2:0], bus.btn_rst_n};
        end
    end

    assign locked_s = lock_sync[SYNC_N-1];
    assign btn_s    = btn_sync[SYNC_N-1];

`ifdef PLL_RESET_SEQ_DEBOUNCE_EN
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_deb;
    logic [DEB_W-1:0] deb_cnt;

    // btn_deb follows btn_s only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_deb <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_s != btn_deb) begin
            if (deb_cnt == DEB_LAST) begin
                btn_deb <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign btn_use = btn_deb;
`else
    assign btn_use = btn_s;

    // Keeps the debounce parameter referenced when the feature is compiled out.
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

    // Priority: button, then lock loss, then counter terminal events.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        retries_nxt = retries;
        lost_nxt    = lost;
        if (!btn_use) begin
            // Held in PLL_RST with the count frozen at zero until release.
            state_nxt = S_PLL_RST;
            cnt_nxt   = '0;
        end else if (!locked_s &&
                     (state == S_STABLE || state == S_SYS_REL || state == S_RUN)) begin
            // Lock dropped: go back to waiting without pulsing the PLL.
            // Only a drop after sys release counts as a lost lock.
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
            if (state != S_STABLE) begin
                lost_nxt = 1'b1;
            end
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == PLL_RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt = S_PLL_RST;
                        cnt_nxt   = '0;
                        if (retries != 4'hF) begin
                            retries_nxt = retries + 4'd1;
                        end
                    end
                end
                S_STABLE: begin
                    if (cnt == STABLE_LAST) begin
                        state_nxt = S_SYS_REL;
                        cnt_nxt   = '0;
                    end
                end
                S_SYS_REL: begin
                    if (cnt == STAGGER_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    // Nothing to time out here; freeze the count instead of wrapping.
                    cnt_nxt = cnt;
                end
                default: begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            retries   <= '0;
            lost      <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retries   <= retries_nxt;
            lost      <= lost_nxt;
            pll_rst_q <= (state_nxt == S_PLL_RST);
            sys_rst_q <= (state_nxt == S_SYS_REL) || (state_nxt == S_RUN);
            cpu_rst_q <= (state_nxt == S_RUN);
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst_n    = sys_rst_q;
    assign bus.cpu_rst_n    = cpu_rst_q;
    assign bus.lock_retries = retries;
    assign bus.lock_lost    = lost;

endmodule
